gb_scandoubler: RTL and testbench

Line doubler downstream of the Game Boy LCD timing generator. Accepts its 8-bit RGB pixel stream with hs/vs/hblank/vblank at the native pixel rate. Re-emits each input line twice at double pixel rate from a two-bank line buffer, giving a VGA-compatible line frequency; the output lags the input by one input line. An optional scanline effect halves intensity on the second repeat of each line.

---
 rtl/gb_scandoubler_pkg.sv | 28 ++
 rtl/gb_scandoubler_if.sv | 25 ++
 rtl/gb_scandoubler_line_ram.sv | 42 ++++
 rtl/gb_scandoubler.sv | 194 +++++++++++++++++++
 tb/tb_gb_scandoubler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gb_scandoubler_pkg.sv
// gb_video_pkg: shared types and constants for the Game Boy scandoubler.
//   RGB_W  : colour channel width
//   PIX_W  : width of one stored line-buffer word {hblank, r, g, b}
//   pix_t  : packed line-buffer word
//   scan_dim() : per-channel right shift used for the scanline effect
package gb_video_pkg;

    localparam int RGB_W = 8;
    localparam int PIX_W = 1 + 3 * RGB_W;

    typedef struct packed {
        logic             hblank;
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } pix_t;

    // Darkens a pixel by shifting each colour channel right; hblank passes through.
    function automatic pix_t scan_dim(input pix_t p, input int unsigned shift);
        pix_t q;
        q.hblank = p.hblank;
        q.r      = p.r >> shift;
        q.g      = p.g >> shift;
        q.b      = p.b >> shift;
        return q;
    endfunction

endpackage

// File: rtl/gb_scandoubler_if.sv
// gb_scandoubler_if: one video stream (pixel enable, syncs, blanking, colour).
//   ce_pix  : pixel enable, owned by the clock/timing side, never by the stream producer
//   hs      : hsync, active low
//   vs      : vsync, active high
//   hblank, vblank : blanking flags
//   r, g, b : colour
// Modports:
//   master : produces the stream (drives syncs/blanking/colour, samples ce_pix)
//   slave  : consumes the stream (samples everything)
interface gb_scandoubler_if;
    import gb_video_pkg::*;

    logic             ce_pix;
    logic             hs;
    logic             vs;
    logic             hblank;
    logic             vblank;
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;

    modport master (input ce_pix, output hs, vs, hblank, vblank, r, g, b);
    modport slave  (input ce_pix, hs, vs, hblank, vblank, r, g, b);

endinterface

// File: rtl/gb_scandoubler_line_ram.sv
// gb_line_ram: simple dual-port line buffer, one write port and one registered
// read port. The bank select is the address MSB, so depth is 2^(ADDR_W+1).
//   clk   : clock
//   we    : write enable
//   waddr : write address {bank, pixel}
//   wdata : stored word
//   re    : read enable; rdata updates only when re is high
//   raddr : read address {bank, pixel}
//   rdata : registered read data (old data on a same-address write)
module gb_line_ram
    import gb_video_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ADDR_W:0] waddr,
    input  pix_t            wdata,
    input  logic            re,
    input  logic [ADDR_W:0] raddr,
    output pix_t            rdata
);

    localparam int DEPTH = 1 << (ADDR_W + 1);

    pix_t mem [DEPTH];

    // NOTE: the storage array has no reset; clearing it would block RAM inference,
    // and the control logic never reads a location that the current line did not write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gb_scandoubler.sv
// gb_scandoubler: Game Boy line doubler. Each input line is stored in one bank
// of a two-bank line buffer while the previous line is replayed twice from the
// other bank at double pixel rate, giving one input line of latency.
//   clk       : clock, all logic on the rising edge
//   reset     : synchronous, active high
//   scanlines : halves (SCAN_SHIFT) the intensity of the second repeat
//   vin       : input stream at native rate, vin.ce_pix is ce_pix_in
//   vout      : output stream at double rate, vout.ce_pix is ce_pix_out (input)
module gb_scandoubler
    import gb_video_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int SCAN_SHIFT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic scanlines,
    gb_scandoubler_if.slave  vin,
    gb_scandoubler_if.master vout
);

    localparam logic [ADDR_W-1:0] HCNT_MAX = '1;

    // ---------------- input side ----------------
    logic              hs_prev;
    logic [ADDR_W-1:0] in_hcnt;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W:0]   line_len;
    logic [ADDR_W-1:0] hs_width;
    logic              vs_line;
    logic              vb_line;

    // ---------------- output side ---------------
    logic [ADDR_W-1:0] out_hcnt;
    logic              out_half;
    logic [ADDR_W-1:0] out_hcnt_d;
    logic              out_half_d;
    logic              rd_valid;

    logic              hs_q;
    logic              vs_q;
    logic              hblank_q;
    logic              vblank_q;
    logic [RGB_W-1:0]  r_q;
    logic [RGB_W-1:0]  g_q;
    logic [RGB_W-1:0]  b_q;

    logic              line_start;
    logic              hs_rise;
    logic              out_active;
    logic [ADDR_W:0]   len_m1;
    logic              at_last;
    pix_t              wr_pix;
    pix_t              rd_pix;
    pix_t              shade_pix;

    assign line_start = vin.ce_pix && hs_prev && !vin.hs;
    assign hs_rise    = vin.ce_pix && !hs_prev && vin.hs;

    // The output counter only runs once a complete line has been captured.
    assign out_active = vout.ce_pix && (line_len != '0);
    assign len_m1     = line_len - 1'b1;
    assign at_last    = ({1'b0, out_hcnt} == len_m1);

    assign wr_pix.hblank = vin.hblank;
    assign wr_pix.r      = vin.r;
    assign wr_pix.g      = vin.g;
    assign wr_pix.b      = vin.b;

    gb_line_ram #(
        .ADDR_W (ADDR_W)
    ) u_line_ram (
        .clk   (clk),
        .we    (vin.ce_pix),
        .waddr ({wr_bank, in_hcnt}),
        .wdata (wr_pix),
        .re    (out_active),
        .raddr ({rd_bank, out_hcnt}),
        .rdata (rd_pix)
    );

    // Input capture. The pixel sampled with the hs falling edge is still the
    // last pixel of the old line, hence line_len = in_hcnt + 1. in_hcnt
    // saturates, so line_len tops out at exactly 2^ADDR_W without extra logic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev  <= 1'b1;
            in_hcnt  <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b1;
            line_len <= '0;
            hs_width <= '0;
            vs_line  <= 1'b0;
            vb_line  <= 1'b0;
        end else if (vin.ce_pix) begin
            hs_prev <= vin.hs;
            if (line_start) begin
                line_len <= {1'b0, in_hcnt} + 1'b1;
                in_hcnt  <= '0;
                wr_bank  <= ~wr_bank;
                rd_bank  <= wr_bank;
                vs_line  <= vin.vs;
                vb_line  <= vin.vblank;
            end else if (in_hcnt != HCNT_MAX) begin
                in_hcnt <= in_hcnt + 1'b1;
            end
            if (hs_rise) begin
                hs_width <= in_hcnt;
            end
        end
    end

    // Output address counter. A line start always wins over the increment so a
    // shorter input line truncates the replay immediately; after the second
    // pass the counter parks on the last pixel instead of starting a third.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_hcnt   <= '0;
            out_half   <= 1'b0;
            out_hcnt_d <= '0;
            out_half_d <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            if (out_active) begin
                out_hcnt_d <= out_hcnt;
                out_half_d <= out_half;
                rd_valid   <= 1'b1;
            end
            if (line_start) begin
                out_hcnt <= '0;
                out_half <= 1'b0;
            end else if (out_active) begin
                if (at_last) begin
                    if (!out_half) begin
                        out_hcnt <= '0;
                        out_half <= 1'b1;
                    end
                end else begin
                    out_hcnt <= out_hcnt + 1'b1;
                end
            end
        end
    end

    // Scanline darkening and blanking of the word read for out_hcnt_d.
    // NOTE: give every always_comb target a default up front so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shade_pix = rd_pix;
        if (scanlines && out_half_d) begin
            shade_pix = scan_dim(rd_pix, SCAN_SHIFT);
        end
        if (rd_pix.hblank || vb_line) begin
            shade_pix.r = '0;
            shade_pix.g = '0;
            shade_pix.b = '0;
        end
    end

    // Output register: one ce_pix_out behind the address, so colour, syncs and
    // blanking all come from the same pixel slot. rd_valid keeps the first
    // slot after reset from loading a word that was never read.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else if (out_active && rd_valid) begin
            hs_q     <= !(out_hcnt_d < hs_width);
            vs_q     <= vs_line;
            hblank_q <= rd_pix.hblank;
            vblank_q <= vb_line;
            r_q      <= shade_pix.r;
            g_q      <= shade_pix.g;
            b_q      <= shade_pix.b;
        end
    end

    assign vout.hs     = hs_q;
    assign vout.vs     = vs_q;
    assign vout.hblank = hblank_q;
    assign vout.vblank = vblank_q;
    assign vout.r      = r_q;
    assign vout.g      = g_q;
    assign vout.b      = b_q;

endmodule

// File: tb/tb_gb_scandoubler.sv
// Self-checking bench for gb_scandoubler. A line-level reference model keeps
// each captured input line as a queue and predicts every output pixel slot
// from its index since the last line start.
module tb_gb_scandoubler;
    import gb_video_pkg::*;

    localparam int ADDR_W     = 9;
    localparam int SCAN_SHIFT = 1;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    logic scanlines;

    gb_scandoubler_if vin ();
    gb_scandoubler_if vout ();

    gb_scandoubler #(
        .ADDR_W     (ADDR_W),
        .SCAN_SHIFT (SCAN_SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scanlines (scanlines),
        .vin       (vin),
        .vout      (vout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   m_hs_prev;
    pix_t m_cap [$];
    pix_t m_disp [DEPTH];
    int   m_len;
    int   m_hsw;
    int   m_j;
    bit   m_vs;
    bit   m_vb;
    bit   m_pend_valid;
    bit   m_pend_half;
    int   m_pend_addr;
    pix_t m_pend_word;

    bit         e_hs;
    bit         e_vs;
    bit         e_hb;
    bit         e_vb;
    logic [7:0] e_r;
    logic [7:0] e_g;
    logic [7:0] e_b;

    task automatic model_reset();
        m_hs_prev    = 1'b1;
        m_cap.delete();
        m_len        = 0;
        m_hsw        = 0;
        m_j          = 0;
        m_vs         = 1'b0;
        m_vb         = 1'b0;
        m_pend_valid = 1'b0;
        m_pend_half  = 1'b0;
        m_pend_addr  = 0;
        m_pend_word  = '0;
        e_hs = 1'b1; e_vs = 1'b0; e_hb = 1'b1; e_vb = 1'b1;
        e_r  = 8'h00; e_g = 8'h00; e_b = 8'h00;
    endtask

    task automatic model_step(input bit ce_i, input bit ce_o, input bit hs, input bit vs,
                              input bit vb, input bit scan, input pix_t w);
        int addr;
        int div;
        div = 1 << SCAN_SHIFT;
        // Output slot: show the word fetched at the previous slot, then fetch
        // the word for slot m_j (first pass, second pass, then park on the last).
        if (ce_o && m_len > 0) begin
            if (m_pend_valid) begin
                e_hs = !(m_pend_addr < m_hsw);
                e_vs = m_vs;
                e_vb = m_vb;
                e_hb = m_pend_word.hblank;
                e_r  = m_pend_word.r;
                e_g  = m_pend_word.g;
                e_b  = m_pend_word.b;
                if (scan && m_pend_half) begin
                    e_r = 8'(int'(e_r) / div);
                    e_g = 8'(int'(e_g) / div);
                    e_b = 8'(int'(e_b) / div);
                end
                if (e_hb || e_vb) begin
                    e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
                end
            end
            if (m_j < m_len)                   addr = m_j;
            else if (m_j - m_len < m_len - 1)  addr = m_j - m_len;
            else                               addr = m_len - 1;
            m_pend_word  = m_disp[addr];
            m_pend_addr  = addr;
            m_pend_half  = (m_j >= m_len);
            m_pend_valid = 1'b1;
            if (m_j < 2 * m_len) m_j++;
        end
        // Input pixel: append to the current line (last slot reused once full).
        if (ce_i) begin
            if (!m_hs_prev && hs) begin
                m_hsw = (m_cap.size() < DEPTH) ? m_cap.size() : DEPTH - 1;
            end
            if (m_cap.size() < DEPTH) m_cap.push_back(w);
            else                      m_cap[DEPTH-1] = w;
            if (m_hs_prev && !hs) begin
                m_len = m_cap.size();
                foreach (m_cap[i]) m_disp[i] = m_cap[i];
                m_cap.delete();
                m_vs = vs;
                m_vb = vb;
                m_j  = 0;
            end
            m_hs_prev = hs;
        end
    endtask

    // ---------------- stimulus ----------------
    int out_phase;

    task automatic tick(input bit ce_i, input bit ce_o);
        pix_t w;
        vin.ce_pix  = ce_i;
        vout.ce_pix = ce_o;
        w.hblank = vin.hblank;
        w.r      = vin.r;
        w.g      = vin.g;
        w.b      = vin.b;
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(ce_i, ce_o, vin.hs, vin.vs, vin.vblank, scanlines, w);
        #1;
        check("sync", {28'd0, vout.hs, vout.vs, vout.hblank, vout.vblank}, {28'd0, e_hs, e_vs, e_hb, e_vb});
        check("rgb", {8'd0, vout.r, vout.g, vout.b}, {8'd0, e_r, e_g, e_b});
    endtask

    // One input line: hs low for 20 pixels starting 50 before the end,
    // ce_pix_in every 4 clk, ce_pix_out every 2 clk at the chosen phase.
    // rst_at >= 0 pulses reset for one clk at that pixel.
    task automatic send_line(input int len, input int vis, input bit vs, input bit vb,
                             input int mode, input int rst_at);
        int hs_lo;
        hs_lo = len - 50;
        for (int p = 0; p < len; p++) begin
            vin.hs     = !(p >= hs_lo && p < hs_lo + 20);
            vin.vs     = vs;
            vin.vblank = vb;
            vin.hblank = (p >= vis);
            case (mode)
                0: begin
                    vin.r = 8'(p);
                    vin.g = 8'(p + 1);
                    vin.b = 8'(p + 2);
                end
                1: begin
                    vin.r = 8'hFE; vin.g = 8'hFE; vin.b = 8'hFE;
                end
                default: begin
                    vin.r = 8'($urandom);
                    vin.g = 8'($urandom);
                    vin.b = 8'($urandom);
                end
            endcase
            for (int c = 0; c < 4; c++) begin
                reset = (p == rst_at && c == 1);
                tick(c == 0, (c % 2) == out_phase);
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        scanlines  = 1'b0;
        out_phase  = 0;
        vin.hs     = 1'b1;
        vin.vs     = 1'b0;
        vin.hblank = 1'b0;
        vin.vblank = 1'b0;
        vin.r      = 8'h00;
        vin.g      = 8'h00;
        vin.b      = 8'h00;
        repeat (3) tick(1'b0, 1'b0);
        reset = 1'b0;

        // Idle with pixel enables running but no hs edge: outputs stay at reset.
        for (int c = 0; c < 40; c++) tick(c % 4 == 0, c % 2 == 0);

        // 228-pixel ramp lines, coincident enables, vsync/vblank over two lines.
        for (int l = 0; l < 8; l++) send_line(228, 160, l == 3 || l == 4, l == 3 || l == 4, 0, -1);

        // Scanline effect on and off with a flat 8'hFE field.
        scanlines = 1'b1;
        repeat (3) send_line(228, 160, 1'b0, 1'b0, 1, -1);
        scanlines = 1'b0;
        repeat (2) send_line(228, 160, 1'b0, 1'b0, 1, -1);

        // Offset enable phase; an over-long line saturates the buffer.
        out_phase = 1;
        send_line(228, 160, 1'b0, 1'b0, 2, -1);
        send_line(600, 520, 1'b0, 1'b0, 2, -1);
        repeat (2) send_line(228, 160, 1'b0, 1'b0, 2, -1);

        // Reset pulse mid-line, then recovery from the next hs falling edge.
        out_phase = 0;
        send_line(228, 160, 1'b0, 1'b0, 0, 100);
        repeat (3) send_line(228, 160, 1'b0, 1'b0, 0, -1);

        // Randomised line lengths (truncation / parking), phase, scanlines, vsync.
        for (int l = 0; l < 12; l++) begin
            int len;
            len       = $urandom_range(200, 260);
            out_phase = $urandom_range(0, 1);
            scanlines = 1'($urandom_range(0, 1));
            send_line(len, len - 68, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
